// File: rtl/mips_regfile.sv
// 32 x 32-bit MIPS register file: two operand read ports, one write port, one debug port.
// R0 reads as zero and is not stored; an optional bypass forwards same-cycle write data.
module mips_regfile #(
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    input  logic [4:0]  DbgReg,
    output logic [31:0] DbgData
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_all [32];
    logic        wr_en;
    logic        byp1;
    logic        byp2;

    // rst_n gates the enable so bypass is suppressed while reset is held.
    assign wr_en = RegWrite && rst_n && (WriteReg != 5'd0);

    assign regs_all[0] = 32'h0000_0000;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[i] <= 32'h0000_0000;
            end else if (wr_en && (WriteReg == 5'(i))) begin
                regs_q[i] <= WriteData;
            end
        end
        assign regs_all[i] = regs_q[i];
    end

    // wr_en already excludes index 0, so a bypass never lands on $zero.
    assign byp1 = WRITE_FIRST && wr_en && (WriteReg == ReadReg1);
    assign byp2 = WRITE_FIRST && wr_en && (WriteReg == ReadReg2);

    always_comb begin
        ReadData1 = byp1 ? WriteData : regs_all[ReadReg1];
        ReadData2 = byp2 ? WriteData : regs_all[ReadReg2];
        DbgData   = regs_all[DbgReg];
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Randomised scoreboard bench for mips_regfile; runs a write-first and a stored-read
// instance side by side against an array-based reference model.
module tb_mips_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  DbgReg;
    logic [31:0] rd1_wf, rd2_wf, dbg_wf;
    logic [31:0] rd1_nb, rd2_nb, dbg_nb;

    mips_regfile #(.WRITE_FIRST(1'b1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_wf), .ReadData2(rd2_wf), .DbgReg(DbgReg), .DbgData(dbg_wf)
    );

    mips_regfile #(.WRITE_FIRST(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_nb), .ReadData2(rd2_nb), .DbgReg(DbgReg), .DbgData(dbg_nb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1_wf, rd2_wf, dbg_wf, rd1_nb, rd2_nb, dbg_nb;
    } exp_t;

    exp_t        exp_q[$];
    string       name_q[$];
    logic [31:0] mem [32];
    int          checks = 0;
    int          failures = 0;
    int          pushes = 0;
    int          pops = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference read: index 0 is zero, bypass only on a live write to that index.
    function automatic logic [31:0] model_read(input logic [4:0] idx, input bit bypass);
        if (idx == 5'd0) return 32'h0;
        if (bypass && rst_n && RegWrite && WriteReg == idx) return WriteData;
        return mem[idx];
    endfunction

    // Monitor: compares every queued expectation mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            pops++;
            check({nm, ".rd1_wf"}, rd1_wf, e.rd1_wf);
            check({nm, ".rd2_wf"}, rd2_wf, e.rd2_wf);
            check({nm, ".dbg_wf"}, dbg_wf, e.dbg_wf);
            check({nm, ".rd1_nb"}, rd1_nb, e.rd1_nb);
            check({nm, ".rd2_nb"}, rd2_nb, e.rd2_nb);
            check({nm, ".dbg_nb"}, dbg_nb, e.dbg_nb);
        end
    end

    // One cycle: retire the write captured on this edge into the model, apply new
    // inputs (optionally changing reset), then queue what the outputs must show.
    task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] dbg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (rst_n && RegWrite && WriteReg != 5'd0) mem[WriteReg] = WriteData;
        rst_n = rst; RegWrite = we; WriteReg = wr; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2; DbgReg = dbg;
        if (!rst) for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        e.rd1_wf = model_read(r1, 1'b1);
        e.rd2_wf = model_read(r2, 1'b1);
        e.dbg_wf = model_read(dbg, 1'b0);
        e.rd1_nb = model_read(r1, 1'b0);
        e.rd2_nb = model_read(r2, 1'b0);
        e.dbg_nb = model_read(dbg, 1'b0);
        exp_q.push_back(e);
        name_q.push_back(nm);
        pushes++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] a, b, c, d;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        ReadReg1 = '0; ReadReg2 = '0; DbgReg = '0;

        step(1'b0, 1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd9, 5'd9, "reset_hold");
        step(1'b0, 1'b1, 5'd4, 32'hCAFE_F00D, 5'd4, 5'd1, 5'd4, "reset_hold2");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd4, 5'd31, "reset_release");

        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd3, "wr_r5");
        step(1'b1, 1'b1, 5'd31, 32'h0000_00FF, 5'd5, 5'd0, 5'd5, "wr_r31");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd31, "readback");

        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, "zero_write");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "zero_after");

        step(1'b1, 1'b1, 5'd7, 32'h1111_1111, 5'd6, 5'd6, 5'd7, "wr_r7");
        step(1'b1, 1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd7, 5'd7, "bypass_r7");
        step(1'b1, 1'b0, 5'd7, 32'h3333_3333, 5'd7, 5'd7, 5'd7, "after_r7");

        step(1'b1, 1'b1, 5'd3, 32'h0BAD_0BAD, 5'd3, 5'd3, 5'd3, "wr_r3");
        step(1'b1, 1'b0, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, 5'd3, "we0_r3");
        step(1'b1, 1'b0, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, 5'd3, "we0_after");

        for (int n = 0; n < 1000; n++) begin
            // Half the cycles stay within R0..R7 to force write/read collisions.
            if ($urandom_range(0, 1) == 0) begin
                a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7));
                c = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
            end else begin
                a = 5'($urandom_range(0, 31)); b = 5'($urandom_range(0, 31));
                c = 5'($urandom_range(0, 31)); d = 5'($urandom_range(0, 31));
            end
            step(1'b1, 1'($urandom_range(0, 3) != 0), a, $urandom(), b, c, d, "random");
        end

        // Reset dropped mid-cycle with a write pending: everything reads zero at once.
        step(1'b0, 1'b1, 5'd12, 32'h7777_7777, 5'd12, 5'd5, 5'd31, "reset_mid");
        for (int n = 0; n < 8; n++) begin
            step(1'b0, 1'b1, 5'($urandom_range(0, 31)), $urandom(),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), "reset_scan");
        end
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd7, "post_reset");
        step(1'b1, 1'b1, 5'd12, 32'h8888_8888, 5'd12, 5'd12, 5'd12, "post_reset_wr");
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd12, "post_reset_rd");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || pops != pushes) begin
            failures++;
            $display("FAIL drain: got pops=%0d expected pops=%0d", pops, pushes);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
